dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
// Direct-mapped, write-back, write-allocate data cache between the memory stage (master on
// dcache_if) and the word-wide external memory bus. Accepts one load/store at a time, performs
// byte/half/word lane alignment, sign extension and store merging, and refills/evicts lines word by word.
// PARAMETERS
// LINES       64  number of cache lines (power of 2)
// LINE_WORDS  4   32-bit words per line (power of 2, >=2)
// PORTS
// clk               in   1   clock
// rst               in   1   asynchronous, active-high reset
// dcache_if.slave   --   --  fields below, seen from this block
//  req_valid        in   1   1-cycle request pulse; sampled only while resp_ready=1
//  req_addr         in   32  byte address
//  write_en         in   1   1=store, 0=load
//  write_data       in   32  store data, right-justified
//  size             in   2   mem_size_t: MEM_SIZE_B/H/W
//  sign             in   1   load sign-extend enable
//  resp_ready       out  1   1 = idle, can accept a request
//  resp_valid       out  1   1-cycle completion pulse (loads and stores)
//  resp_data        out  32  aligned/extended load data; 0 for stores
// mem_req_valid     out  1   memory word request
// mem_req_ready     in   1   memory accepts request this cycle
// mem_we            out  1   1=write word, 0=read word
// mem_addr          out  32  word-aligned address
// mem_wdata         out  32  eviction data
// mem_rvalid        in   1   read data valid (one outstanding read max)
// mem_rdata         in   32  read data
// BEHAVIOUR
// - Reset: state IDLE, resp_ready=1, resp_valid=0, resp_data=0, mem_req_valid=0, mem_we=0,
//   mem_addr=0, mem_wdata=0; all valid/dirty bits 0; data/tag arrays not reset.
//   Reset mid-refill/evict aborts immediately; mem_req_valid drops with rst; partial line stays invalid.
// - Address split: offset[1:0], word = next log2(LINE_WORDS) bits, index = next log2(LINES), tag = rest.
// - Request captured into registers on req_valid && resp_ready; resp_ready drops next cycle.
//   req_valid while resp_ready=0 is ignored (master protocol violation, not buffered).
// - FSM: IDLE -> LOOKUP (always). LOOKUP: hit -> RESP; miss & victim dirty -> EVICT; miss & clean -> REFILL.
//   EVICT: LINE_WORDS write beats (mem_we=1), beat advances on mem_req_valid&&mem_req_ready; last -> REFILL.
//   REFILL: per word issue read (mem_req_valid until ready), then wait mem_rvalid, write word into
//   data array; after word LINE_WORDS-1 set valid=1, dirty=0, tag -> LOOKUP (guaranteed hit).
//   RESP: resp_valid=1 for exactly one cycle -> IDLE.
// - Beat counter wraps at LINE_WORDS-1; beats issued in order from word 0.
// - Hit latency: request edge T, LOOKUP T+1, resp_valid T+2, resp_ready=1 at T+3.
// - Load: word shifted right by 8*offset; B uses bits[7:0], H bits[15:0]; sign=1 extends MSB, else zero.
//   W ignores sign. Misaligned H (offset[0]=1) / W (offset!=0): offset low bits forced to 0 (aligned down).
// - Store: byte enables B=1<<off, H=3<<{off[1],1'b0}, W=4'hF; merged into word in LOOKUP-hit cycle,
//   dirty=1; resp_data=0.
// - mem_rdata is never forwarded directly to resp_data; loads always read the array in LOOKUP.
// STRUCTURE
// - _pkg_riscv_defines: DATA_WIDTH, mem_size_t/MEM_SIZE_*, new dcache_state_t
//   {DC_IDLE, DC_LOOKUP, DC_EVICT, DC_REFILL, DC_RESP}.
// - Sub-module dcache_lane_align (combinational): load extract/sign-extend and store byte-enable/merge.
// - Tag/valid/dirty/data arrays as flop arrays inside dcache_ctrl; localparams derive widths via $clog2.
// TESTING
// - Cold load LW 0x100 (mem word 0x100 = 0xDEADBEEF, 1-cycle mem) -> 4 reads 0x100..0x10C, resp_data=0xDEADBEEF.
// - Re-load LB 0x103 sign=1 then LBU 0x103 -> hits, latency 2, resp_data 0xFFFFFFDE then 0x000000DE.
// - SH 0x102 data 0x1234 then LW 0x100 -> hit, resp_data 0x1234BEEF, no mem traffic, line dirty.
// - LW 0x100+LINES*LINE_WORDS*4 (same index) -> 4 writes 0x100.. with word0=0x1234BEEF, then 4 reads, respond.
// - mem_req_ready held 0 for 5 cycles mid-refill -> mem_req_valid/mem_addr stable, no resp_valid until done.
// - rst pulsed during REFILL beat 2 -> outputs at reset values, next LW same address misses and refills fully.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the data cache controller: access sizes, FSM states and the captured request.
package dcache_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        DC_IDLE,
        DC_LOOKUP,
        DC_EVICT,
        DC_REFILL,
        DC_RESP
    } dcache_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        mem_size_t             size;
        logic                  sign;
    } dc_req_t;

endpackage

// File: rtl/dcache_ctrl_lane_align.sv
// Combinational byte-lane logic: load extract/sign-extend and store byte-enable merge.
module dcache_lane_align
    import dcache_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            offset_i,
    input  mem_size_t             size_i,
    input  logic                  sign_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] load_o,
    output logic [DATA_WIDTH-1:0] merged_o
);

    logic [1:0]            aoff;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wpos;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        aoff     = 2'b00;
        be       = 4'hF;
        wpos     = wdata_i;
        load_o   = '0;
        merged_o = word_i;
        // Misaligned halves/words are aligned down rather than split across words.
        case (size_i)
            MEM_SIZE_B: begin
                aoff = offset_i;
                be   = 4'b0001 << offset_i;
                wpos = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                aoff = {offset_i[1], 1'b0};
                be   = 4'b0011 << {offset_i[1], 1'b0};
                wpos = {2{wdata_i[15:0]}};
            end
            default: begin
                aoff = 2'b00;
                be   = 4'hF;
                wpos = wdata_i;
            end
        endcase
        shifted = word_i >> {aoff, 3'b000};
        case (size_i)
            MEM_SIZE_B: load_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_H: load_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
            default:    load_o = shifted;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_o[8*i +: 8] = be[i] ? wpos[8*i +: 8] : word_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache; one access at a time,
// word-by-word eviction and refill over a single-outstanding-read memory bus.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [1:0]            size,
    input  logic                  sign,
    output logic                  resp_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = 2 + WORD_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = DATA_WIDTH - TAG_LSB;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    dcache_state_t         state_q, state_d;
    dc_req_t               req_q, req_d;
    logic [WORD_W-1:0]     beat_q, beat_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;

    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES][LINE_WORDS];

    logic                  data_we;
    logic [WORD_W-1:0]     data_word;
    logic [DATA_WIDTH-1:0] data_wval;
    logic                  tag_we;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_W-1:0]     req_word;
    logic                  hit;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_data;

    assign idx      = req_q.addr[TAG_LSB-1:IDX_LSB];
    assign req_tag  = req_q.addr[DATA_WIDTH-1:TAG_LSB];
    assign req_word = req_q.addr[IDX_LSB-1:2];
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

    dcache_lane_align u_align (
        .word_i   (data_q[idx][req_word]),
        .offset_i (req_q.addr[1:0]),
        .size_i   (req_q.size),
        .sign_i   (req_q.sign),
        .wdata_i  (req_q.wdata),
        .load_o   (load_data),
        .merged_o (merged_data)
    );

    assign resp_ready = (state_q == DC_IDLE);
    assign resp_valid = (state_q == DC_RESP);
    assign resp_data  = resp_data_q;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        beat_d        = beat_q;
        rd_pend_d     = rd_pend_q;
        resp_data_d   = resp_data_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        data_we       = 1'b0;
        data_word     = beat_q;
        data_wval     = mem_rdata;
        tag_we        = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state_q)
            DC_IDLE: begin
                if (req_valid) begin
                    req_d.addr  = req_addr;
                    req_d.we    = write_en;
                    req_d.wdata = write_data;
                    req_d.size  = mem_size_t'(size);
                    req_d.sign  = sign;
                    state_d     = DC_LOOKUP;
                end
            end
            DC_LOOKUP: begin
                if (hit) begin
                    if (req_q.we) begin
                        data_we      = 1'b1;
                        data_word    = req_word;
                        data_wval    = merged_data;
                        dirty_d[idx] = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        resp_data_d  = load_data;
                    end
                    state_d = DC_RESP;
                end else begin
                    // Line is invalid from here until the last refill word lands.
                    valid_d[idx] = 1'b0;
                    beat_d       = '0;
                    rd_pend_d    = 1'b0;
                    state_d      = (valid_q[idx] && dirty_q[idx]) ? DC_EVICT : DC_REFILL;
                end
            end
            DC_EVICT: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = {tag_q[idx], idx, beat_q, 2'b00};
                mem_wdata     = data_q[idx][beat_q];
                if (mem_req_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = DC_REFILL;
                end
            end
            DC_REFILL: begin
                mem_addr = {req_tag, idx, beat_q, 2'b00};
                if (!rd_pend_q) begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) rd_pend_d = 1'b1;
                end else if (mem_rvalid) begin
                    data_we   = 1'b1;
                    rd_pend_d = 1'b0;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        valid_d[idx] = 1'b1;
                        dirty_d[idx] = 1'b0;
                        tag_we       = 1'b1;
                        state_d      = DC_LOOKUP;
                    end
                end
            end
            DC_RESP: state_d = DC_IDLE;
            default: state_d = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DC_IDLE;
            req_q       <= '0;
            beat_q      <= '0;
            rd_pend_q   <= 1'b0;
            resp_data_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            beat_q      <= beat_d;
            rd_pend_q   <= rd_pend_d;
            resp_data_q <= resp_data_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Storage arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (data_we) data_q[idx][data_word] <= data_wval;
        if (tag_we)  tag_q[idx]             <= req_tag;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized traffic against a
// flat-memory reference with a per-index tag/dirty model for expected bus traffic.
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    localparam int LINES      = 64;
    localparam int LW         = 4;
    localparam int LINE_BYTES = LW * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        write_en = 1'b0;
    logic [31:0] write_data = '0;
    logic [1:0]  size = 2'd2;
    logic        sign = 1'b0;
    logic        resp_ready, resp_valid;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(LINES), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .write_en(write_en),
        .write_data(write_data), .size(size), .sign(sign),
        .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } beat_t;
    beat_t       log_q[$];
    logic [31:0] mem_arr [int unsigned];
    logic [31:0] gold    [int unsigned];
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    int unsigned m_tag   [LINES];

    bit          rand_ready  = 1'b0;
    int          cyc         = 0;
    int          stall_until = -1;
    bit          rd_pend     = 1'b0;
    logic [31:0] rd_data     = '0;

    function automatic logic [31:0] init_word(int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] mem_rd(int unsigned wa);
        return mem_arr.exists(wa) ? mem_arr[wa] : init_word(wa);
    endfunction
    function automatic logic [31:0] gold_rd(int unsigned wa);
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] w, logic [1:0] off, logic [1:0] sz, bit sg);
        logic [31:0] v;
        int unsigned sh;
        case (sz)
            2'd0: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (sg && v[7]) v = v | 32'hFFFFFF00;
            end
            2'd1: begin
                sh = 8 * (off & 2);
                v = (w >> sh) & 32'hFFFF;
                if (sg && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_store(logic [31:0] w, logic [1:0] off, logic [1:0] sz, logic [31:0] wd);
        logic [31:0] mask, v;
        int unsigned sh;
        case (sz)
            2'd0: begin sh = 8 * off;       mask = 32'hFF << sh;   v = (wd & 32'hFF) << sh;   end
            2'd1: begin sh = 8 * (off & 2); mask = 32'hFFFF << sh; v = (wd & 32'hFFFF) << sh; end
            default: begin mask = 32'hFFFFFFFF; v = wd; end
        endcase
        return (w & ~mask) | (v & mask);
    endfunction

    // Memory responder: decides ready on the falling edge, returns read data one cycle after acceptance.
    always @(negedge clk) begin
        cyc = cyc + 1;
        mem_rvalid = 1'b0;
        if (rst) begin
            rd_pend = 1'b0;
            mem_req_ready = 1'b0;
        end else begin
            if (rd_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data;
                rd_pend    = 1'b0;
            end
            if (cyc <= stall_until) mem_req_ready = 1'b0;
            else mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_req_valid && mem_req_ready) begin
                log_q.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : 32'h0)});
                if (mem_we) mem_arr[mem_addr >> 2] = mem_wdata;
                else begin
                    rd_pend = 1'b1;
                    rd_data = mem_rd(mem_addr >> 2);
                end
            end
        end
    end

    // One access: predicts traffic and result from the model, drives the request, compares inline.
    task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sg,
                         output logic [31:0] rdata, output int lat, output int ntraf);
        int unsigned idx, tag, base;
        beat_t       exp_q[$];
        bit          hit, ok;
        int          start;
        logic [31:0] exp_data;
        idx = (addr >> 4) % LINES;
        tag = addr / (LINE_BYTES * LINES);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < LW; w++) begin
                    base = (m_tag[idx] * LINES + idx) * LINE_BYTES + 4 * w;
                    exp_q.push_back('{we: 1'b1, addr: base, data: gold_rd(base >> 2)});
                end
            end
            for (int w = 0; w < LW; w++) begin
                base = (tag * LINES + idx) * LINE_BYTES + 4 * w;
                exp_q.push_back('{we: 1'b0, addr: base, data: 32'h0});
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        exp_data = we ? 32'h0 : exp_load(gold_rd(addr >> 2), addr[1:0], sz, sg);
        if (we) begin
            gold[addr >> 2] = exp_store(gold_rd(addr >> 2), addr[1:0], sz, wd);
            m_dirty[idx] = 1'b1;
        end
        start = log_q.size();
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; write_en = we; write_data = wd; size = sz; sign = sg;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        ok = 1'b0;
        while (lat < 400) begin
            if (resp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        rdata = resp_data;
        ntraf = log_q.size() - start;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL op_timeout addr=%h got no resp_valid within %0d cycles", addr, lat);
        end
        checks++;
        if (rdata !== exp_data) begin
            errors++;
            $display("FAIL op_data addr=%h we=%0d sz=%0d sg=%0d got %h exp %h", addr, we, sz, sg, rdata, exp_data);
        end
        if (hit) begin
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL hit_latency addr=%h got %0d exp 2", addr, lat);
            end
        end
        checks++;
        if (ntraf !== exp_q.size()) begin
            errors++;
            $display("FAIL traffic_count addr=%h got %0d exp %0d", addr, ntraf, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (log_q[start+i].we !== exp_q[i].we || log_q[start+i].addr !== exp_q[i].addr ||
                    (exp_q[i].we && log_q[start+i].data !== exp_q[i].data)) begin
                    errors++;
                    $display("FAIL traffic_beat%0d addr=%h got we=%0d a=%h d=%h exp we=%0d a=%h d=%h", i, addr,
                             log_q[start+i].we, log_q[start+i].addr, log_q[start+i].data,
                             exp_q[i].we, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (resp_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
            errors++;
            $display("FAIL %s_resp got rdy=%b vld=%b data=%h exp 1 0 0", tag, resp_ready, resp_valid, resp_data);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL %s_mem got v=%b we=%b a=%h d=%h exp 0 0 0 0", tag, mem_req_valid, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_cold_load();
        logic [31:0] d; int lat, n, start;
        mem_arr[32'h100 >> 2] = 32'hDEADBEEF;
        gold[32'h100 >> 2]    = 32'hDEADBEEF;
        start = log_q.size();
        do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, d, lat, n);
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_lw got %h exp deadbeef", d); end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL cold_reads got %0d exp 4", n); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[start+i].we !== 1'b0 || log_q[start+i].addr !== 32'h100 + 4 * i) begin
                    errors++;
                    $display("FAIL cold_addr%0d got we=%0d a=%h exp read %h", i, log_q[start+i].we,
                             log_q[start+i].addr, 32'h100 + 4 * i);
                end
            end
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] d; int lat, n;
        do_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, d, lat, n);
        checks++;
        if (d !== 32'hFFFFFFDE || lat !== 2 || n !== 0) begin
            errors++;
            $display("FAIL lb_signed got d=%h lat=%0d traf=%0d exp ffffffde 2 0", d, lat, n);
        end
        @(negedge clk);
        checks++;
        if (resp_ready !== 1'b1) begin errors++; $display("FAIL ready_after_hit got %b exp 1", resp_ready); end
        do_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, d, lat, n);
        checks++;
        if (d !== 32'h000000DE || lat !== 2) begin
            errors++;
            $display("FAIL lbu got d=%h lat=%0d exp 000000de 2", d, lat);
        end
    endtask

    task automatic test_store_merge();
        logic [31:0] d; int lat, n;
        do_op(1'b1, 32'h102, 32'h1234, 2'd1, 1'b0, d, lat, n);
        checks++;
        if (d !== 32'h0 || n !== 0) begin errors++; $display("FAIL sh_resp got d=%h traf=%0d exp 0 0", d, n); end
        do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, d, lat, n);
        checks++;
        if (d !== 32'h1234BEEF || n !== 0) begin
            errors++;
            $display("FAIL sh_merge got d=%h traf=%0d exp 1234beef 0", d, n);
        end
    endtask

    task automatic test_evict();
        logic [31:0] d; int lat, n, start;
        start = log_q.size();
        do_op(1'b0, 32'h100 + LINES * LINE_BYTES, 32'h0, 2'd2, 1'b0, d, lat, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL evict_count got %0d exp 8", n); end
        else begin
            checks++;
            if (log_q[start].we !== 1'b1 || log_q[start].addr !== 32'h100 || log_q[start].data !== 32'h1234BEEF) begin
                errors++;
                $display("FAIL evict_word0 got we=%0d a=%h d=%h exp 1 100 1234beef",
                         log_q[start].we, log_q[start].addr, log_q[start].data);
            end
            checks++;
            if (log_q[start+4].we !== 1'b0 || log_q[start+4].addr !== 32'h100 + LINES * LINE_BYTES) begin
                errors++;
                $display("FAIL evict_refill0 got we=%0d a=%h exp read %h", log_q[start+4].we,
                         log_q[start+4].addr, 32'h100 + LINES * LINE_BYTES);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d, a0; int lat, n, start, k;
        start = log_q.size();
        fork
            do_op(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, d, lat, n);
            begin
                k = 0;
                while (k < 300 && !(mem_req_valid && !mem_we && log_q.size() >= start + 1)) begin
                    @(posedge clk); #1; k++;
                end
                checks++;
                if (k >= 300) begin errors++; $display("FAIL stall_setup got no refill beat exp one"); end
                stall_until = cyc + 5;
                a0 = mem_addr;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (mem_req_valid !== 1'b1 || mem_addr !== a0 || resp_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold%0d got v=%b a=%h rv=%b exp 1 %h 0", i, mem_req_valid,
                                 mem_addr, resp_valid, a0);
                    end
                end
            end
        join
    endtask

    task automatic test_rst_mid_refill();
        logic [31:0] d; int lat, n, start, k;
        start = log_q.size();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h3000; write_en = 1'b0; size = 2'd2; sign = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (k < 300 && !(mem_req_valid && !mem_we && log_q.size() >= start + 2)) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (k >= 300) begin errors++; $display("FAIL rst_setup got no beat 2 exp one"); end
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        gold = mem_arr;
        start = log_q.size();
        do_op(1'b0, 32'h3000, 32'h0, 2'd2, 1'b0, d, lat, n);
        checks++;
        if (n !== 4 || log_q[start].addr !== 32'h3000) begin
            errors++;
            $display("FAIL rst_refill got traf=%0d first=%h exp 4 00003000", n, log_q[start].addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, a, wd; int lat, n;
        bit we, sg; logic [1:0] sz;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a  = $urandom_range(0, 3) * (LINES * LINE_BYTES) + $urandom_range(0, 2) * LINE_BYTES
                 + $urandom_range(0, LW - 1) * 4 + $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            wd = $urandom;
            do_op(we, a, wd, sz, sg, d, lat, n);
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < LINES; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0; end
        test_reset();
        test_cold_load();
        test_load_ext();
        test_store_merge();
        test_evict();
        test_stall();
        test_rst_mid_refill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
